ext_bus_responder: RTL and testbench

External-memory side of the MCU51 multiplexed bus. The CPU drives ALE, PSEN, RD, WR, the low address/data byte on P0 and the high address on P2. This block decodes those bus cycles, then runs a req/ack transaction on a backing CODE or XDATA memory port. For reads it drives the returned byte onto P0; for writes it captures the byte from P0. It sits between the P0/P2 pad logic and the memory models used in system simulation and FPGA builds.

---
 rtl/ext_bus_responder.sv | 232 +++++++++++++++++++++++
 tb/tb_ext_bus_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_bus_responder.sv
// Purpose : external-memory responder for the MCU51 multiplexed bus (ALE/PSEN/RD/WR, P0/P2).
// Latency : address latched SYNC_STAGES+1 cycles after ALE falls; P0_oe rises 1 cycle after mem_ack.
// Backpres: memory stalls via mem_ack (req held until ack or TIMEOUT); the CPU is never stalled.
//
// Ports:
//   clk, reset                 clock, async active-low reset (deassertion synchronized inside)
//   ALE, PSEN, RD, WR          bus control from the CPU (ALE active high, strobes active low)
//   P0_in, P2_in               pad inputs: P0 = A7..A0 / D7..D0, P2 = A15..A8
//   P0_out, P0_oe              read data and output enable toward the P0 pad
//   mem_req/sel/we/addr/wdata  request to backing memory (sel 0 = CODE, 1 = XDATA)
//   mem_rdata, mem_ack         memory response; ack is a one-cycle pulse
//   bus_err, err_clr           sticky protocol/timeout error and its clear pulse
module ext_bus_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ALE,
  input  logic        PSEN,
  input  logic        RD,
  input  logic        WR,
  input  logic [7:0]  P0_in,
  input  logic [7:0]  P2_in,
  output logic [7:0]  P0_out,
  output logic        P0_oe,
  output logic        mem_req,
  output logic        mem_sel,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err,
  input  logic        err_clr
);

  typedef enum logic [2:0] {IDLE, ADDR, RDREQ, DRIVE, WRCAP, WRREQ} state_t;

  // Reset: assert immediately, release on the clock.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Input synchronizers; all bus inputs share the same depth so data stays aligned with strobes.
  logic [SYNC_STAGES-1:0]      ale_sync, psen_sync, rd_sync, wr_sync;
  logic [SYNC_STAGES-1:0][7:0] p0_sync, p2_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ale_sync  <= '0;
      psen_sync <= '1;
      rd_sync   <= '1;
      wr_sync   <= '1;
      p0_sync   <= '0;
      p2_sync   <= '0;
    end else begin
      ale_sync  <= {ale_sync[SYNC_STAGES-2:0], ALE};
      psen_sync <= {psen_sync[SYNC_STAGES-2:0], PSEN};
      rd_sync   <= {rd_sync[SYNC_STAGES-2:0], RD};
      wr_sync   <= {wr_sync[SYNC_STAGES-2:0], WR};
      p0_sync   <= {p0_sync[SYNC_STAGES-2:0], P0_in};
      p2_sync   <= {p2_sync[SYNC_STAGES-2:0], P2_in};
    end
  end

  logic       ale_s, psen_s, rd_s, wr_s;
  logic [7:0] p0_s, p2_s;
  assign ale_s  = ale_sync[SYNC_STAGES-1];
  assign psen_s = psen_sync[SYNC_STAGES-1];
  assign rd_s   = rd_sync[SYNC_STAGES-1];
  assign wr_s   = wr_sync[SYNC_STAGES-1];
  assign p0_s   = p0_sync[SYNC_STAGES-1];
  assign p2_s   = p2_sync[SYNC_STAGES-1];

  // Previous synchronized levels for edge detection.
  logic ale_p, psen_p, rd_p, wr_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ale_p  <= 1'b0;
      psen_p <= 1'b1;
      rd_p   <= 1'b1;
      wr_p   <= 1'b1;
    end else begin
      ale_p  <= ale_s;
      psen_p <= psen_s;
      rd_p   <= rd_s;
      wr_p   <= wr_s;
    end
  end

  logic       ale_fall, ale_rise, psen_fall, rd_fall, wr_fall, wr_rise, strobe_rise;
  logic [1:0] n_fall;
  logic [7:0] tmo_cnt;
  logic       tmo_hit;

  assign ale_fall  = ale_p & ~ale_s;
  assign ale_rise  = ~ale_p & ale_s;
  assign psen_fall = psen_p & ~psen_s;
  assign rd_fall   = rd_p & ~rd_s;
  assign wr_fall   = wr_p & ~wr_s;
  assign wr_rise   = ~wr_p & wr_s;
  assign n_fall    = {1'b0, psen_fall} + {1'b0, rd_fall} + {1'b0, wr_fall};
  // In DRIVE the strobe that started the read is implied by mem_sel (CODE=PSEN, XDATA=RD).
  assign strobe_rise = mem_sel ? (~rd_p & rd_s) : (~psen_p & psen_s);
  // The counter starts at 0 on entry, so TIMEOUT cycles in a waiting state ends at TIMEOUT-1.
  assign tmo_hit = (tmo_cnt == 8'(TIMEOUT - 1));

  state_t state;
  logic   abort_pend;  // ALE rose while a memory access was in flight

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      P0_out     <= 8'h00;
      P0_oe      <= 1'b0;
      mem_req    <= 1'b0;
      mem_sel    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 16'h0000;
      mem_wdata  <= 8'h00;
      bus_err    <= 1'b0;
      tmo_cnt    <= 8'h00;
      abort_pend <= 1'b0;
    end else begin
      // Clear first; any set below in the same cycle overrides it.
      if (err_clr) bus_err <= 1'b0;

      case (state)
        IDLE: begin
          P0_oe      <= 1'b0;
          abort_pend <= 1'b0;
          if (ale_fall) begin
            mem_addr <= {p2_s, p0_s};
            tmo_cnt  <= 8'h00;
            state    <= ADDR;
          end
        end

        ADDR: begin
          if (ale_rise) begin
            state <= IDLE;
          end else if (n_fall >= 2'd2) begin
            bus_err <= 1'b1;
            state   <= IDLE;
          end else if (psen_fall || rd_fall) begin
            mem_sel <= rd_fall;
            mem_we  <= 1'b0;
            mem_req <= 1'b1;
            tmo_cnt <= 8'h00;
            state   <= RDREQ;
          end else if (wr_fall) begin
            mem_sel   <= 1'b1;
            mem_we    <= 1'b0;
            mem_wdata <= p0_s;
            state     <= WRCAP;
          end else if (tmo_hit) begin
            bus_err <= 1'b1;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        RDREQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (abort_pend || ale_rise) begin
              state <= IDLE;
            end else begin
              P0_out <= mem_rdata;
              P0_oe  <= 1'b1;
              state  <= DRIVE;
            end
          end else if (tmo_hit) begin
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
            if (ale_rise) abort_pend <= 1'b1;
          end
        end

        DRIVE: begin
          if (ale_rise || strobe_rise) begin
            P0_oe <= 1'b0;
            state <= IDLE;
          end
        end

        WRCAP: begin
          // The rise-detect cycle already carries post-strobe data, so it is not sampled.
          if (wr_rise) begin
            mem_req <= 1'b1;
            mem_we  <= 1'b1;
            tmo_cnt <= 8'h00;
            state   <= WRREQ;
          end else if (ale_rise) begin
            state <= IDLE;
          end else begin
            mem_wdata <= p0_s;
          end
        end

        WRREQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= IDLE;
          end else if (tmo_hit) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            bus_err <= 1'b1;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_bus_responder.sv
// Purpose : directed self-checking bench for ext_bus_responder (SYNC_STAGES=2, TIMEOUT=15).
// Latency : expected cycle counts are hand-derived from the bus timing of the block.
// Backpres: the bench plays the memory, returning mem_ack one cycle after mem_req is seen.
module tb_ext_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        ALE, PSEN, RD, WR;
  logic [7:0]  P0_in, P2_in;
  logic [7:0]  P0_out;
  logic        P0_oe;
  logic        mem_req, mem_sel, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        bus_err;
  logic        err_clr;

  int vectors    = 0;
  int miscompares = 0;
  int req_rises  = 0;
  int oe_rises   = 0;
  int base;

  ext_bus_responder #(.SYNC_STAGES(2), .TIMEOUT(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .ALE       (ALE),
    .PSEN      (PSEN),
    .RD        (RD),
    .WR        (WR),
    .P0_in     (P0_in),
    .P2_in     (P2_in),
    .P0_out    (P0_out),
    .P0_oe     (P0_oe),
    .mem_req   (mem_req),
    .mem_sel   (mem_sel),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .bus_err   (bus_err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge mem_req) req_rises++;
  always @(posedge P0_oe)   oe_rises++;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ALE high with the address on the pads, then ALE falls; returns once the latch has happened.
  task automatic addr_phase(input logic [15:0] a);
    P0_in = a[7:0];
    P2_in = a[15:8];
    ALE   = 1'b1;
    tick(3);
    ALE = 1'b0;
    tick(3);
  endtask

  initial begin
    reset = 1'b0; ALE = 1'b0; PSEN = 1'b1; RD = 1'b1; WR = 1'b1;
    P0_in = 8'h00; P2_in = 8'h00; mem_rdata = 8'h00; mem_ack = 1'b0; err_clr = 1'b0;

    // Reset state
    tick(3);
    check("rst_P0_out", P0_out, 16'h00);
    check("rst_P0_oe", P0_oe, 16'h0);
    check("rst_mem_req", mem_req, 16'h0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_mem_wdata", mem_wdata, 16'h00);
    check("rst_bus_err", bus_err, 16'h0);
    reset = 1'b1;
    tick(4);

    // Code fetch from 0x1234, memory returns 0xA5
    P0_in = 8'h34; P2_in = 8'h12; ALE = 1'b1;
    tick(3);
    ALE = 1'b0;
    tick(2);
    check("fetch_addr_early", mem_addr, 16'h0000);
    tick(1);
    check("fetch_addr", mem_addr, 16'h1234);
    P0_in = 8'hFF; PSEN = 1'b0;
    tick(2);
    check("fetch_req_early", mem_req, 16'h0);
    tick(1);
    check("fetch_req", mem_req, 16'h1);
    check("fetch_sel", mem_sel, 16'h0);
    check("fetch_we", mem_we, 16'h0);
    tick(1);
    check("fetch_oe_before_ack", P0_oe, 16'h0);
    mem_rdata = 8'hA5; mem_ack = 1'b1;
    tick(1);
    mem_ack = 1'b0;
    check("fetch_oe", P0_oe, 16'h1);
    check("fetch_P0_out", P0_out, 16'hA5);
    check("fetch_req_drop", mem_req, 16'h0);
    tick(4);
    check("fetch_oe_hold", P0_oe, 16'h1);
    PSEN = 1'b1;
    tick(2);
    check("fetch_oe_late", P0_oe, 16'h1);
    tick(1);
    check("fetch_oe_release", P0_oe, 16'h0);
    tick(2);

    // XDATA write of 0x5A to 0x8001; P0 changes together with WR rising
    addr_phase(16'h8001);
    check("wr_addr", mem_addr, 16'h8001);
    base = req_rises;
    P0_in = 8'h5A; WR = 1'b0;
    tick(3);
    check("wr_sel", mem_sel, 16'h1);
    check("wr_no_req_while_low", mem_req, 16'h0);
    tick(3);
    WR = 1'b1; P0_in = 8'hFF;
    tick(3);
    check("wr_req", mem_req, 16'h1);
    check("wr_we", mem_we, 16'h1);
    check("wr_sel_req", mem_sel, 16'h1);
    check("wr_wdata", mem_wdata, 16'h5A);
    tick(1);
    mem_ack = 1'b1;
    tick(1);
    mem_ack = 1'b0;
    check("wr_req_drop", mem_req, 16'h0);
    tick(4);
    check("wr_one_req", 16'(req_rises - base), 16'd1);
    check("wr_wdata_kept", mem_wdata, 16'h5A);

    // Strobe conflict: RD and PSEN fall together
    addr_phase(16'h0042);
    base = req_rises;
    RD = 1'b0; PSEN = 1'b0;
    tick(3);
    check("conf_err", bus_err, 16'h1);
    check("conf_no_req", mem_req, 16'h0);
    RD = 1'b1; PSEN = 1'b1;
    tick(4);
    check("conf_err_sticky", bus_err, 16'h1);
    check("conf_no_req_rise", 16'(req_rises - base), 16'd0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("conf_err_clr", bus_err, 16'h0);

    // Timeout: RD read with mem_ack withheld
    addr_phase(16'h0100);
    base = oe_rises;
    RD = 1'b0;
    tick(3);
    check("tmo_req", mem_req, 16'h1);
    tick(14);
    check("tmo_req_last", mem_req, 16'h1);
    check("tmo_err_not_yet", bus_err, 16'h0);
    tick(1);
    check("tmo_req_drop", mem_req, 16'h0);
    check("tmo_err", bus_err, 16'h1);
    check("tmo_no_oe", 16'(oe_rises - base), 16'd0);
    RD = 1'b1;
    tick(3);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("tmo_err_clr", bus_err, 16'h0);

    // Abort: ALE rises during DRIVE, then a new address is latched and fetched
    addr_phase(16'h2000);
    RD = 1'b0;
    tick(3);
    check("abort_req", mem_req, 16'h1);
    check("abort_sel", mem_sel, 16'h1);
    tick(1);
    mem_rdata = 8'h3C; mem_ack = 1'b1;
    tick(1);
    mem_ack = 1'b0;
    check("abort_oe", P0_oe, 16'h1);
    check("abort_P0_out", P0_out, 16'h3C);
    tick(2);
    ALE = 1'b1; P0_in = 8'h78; P2_in = 8'h56;
    tick(2);
    check("abort_oe_late", P0_oe, 16'h1);
    tick(1);
    check("abort_oe_drop", P0_oe, 16'h0);
    RD = 1'b1;
    tick(3);
    ALE = 1'b0;
    tick(3);
    check("abort_new_addr", mem_addr, 16'h5678);
    PSEN = 1'b0;
    tick(3);
    check("abort_fetch_req", mem_req, 16'h1);
    check("abort_fetch_sel", mem_sel, 16'h0);
    tick(1);
    mem_rdata = 8'h99; mem_ack = 1'b1;
    tick(1);
    mem_ack = 1'b0;
    check("abort_fetch_data", P0_out, 16'h99);
    check("abort_fetch_oe", P0_oe, 16'h1);
    PSEN = 1'b1;
    tick(3);
    check("abort_fetch_release", P0_oe, 16'h0);

    // Reset asserted mid-RDREQ clears outputs without waiting for a clock
    addr_phase(16'h0F0F);
    RD = 1'b0;
    tick(3);
    check("rreq_req", mem_req, 16'h1);
    #2;
    reset = 1'b0;
    #1;
    check("rreq_rst_req", mem_req, 16'h0);
    check("rreq_rst_oe", P0_oe, 16'h0);
    check("rreq_rst_addr", mem_addr, 16'h0000);
    check("rreq_rst_sel", mem_sel, 16'h0);
    RD = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(4);
    check("post_rst_req", mem_req, 16'h0);
    check("post_rst_err", bus_err, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
